window_buffer_ctrl: RTL and testbench
=====================================

// Module: window_buffer_ctrl
// PURPOSE
//  Sequencer for the MP2 synthesis filterbank V-vector buffer (1024 x 16 single-port block RAM, 1-cycle read latency).
//  Per subband-sample slot: rotates the circular offset by 64, writes 64 new V values from matrixing,
//  then streams the 512 U values needed by windowing in ISO 11172-3 order. Also clears the buffer on demand.
//  Sits between the matrixing stage (V producer), the window buffer RAM, and the windowing MAC (U consumer).
// PARAMETERS
//  DATA_W  16    V/U sample width
//  ADDR_W  10    RAM address width (buffer depth 2**ADDR_W = 1024)
//  V_BLK   64    V values written per slot (offset step)
// PORTS
//  clock           in   1       system clock, rising edge
//  resetn          in   1       asynchronous active-low reset
//  start_i         in   1       pulse: begin one slot (write 64 V, read 512 U); ignored unless idle
//  clear_i         in   1       pulse: zero all 1024 words, offset:=0; ignored unless idle; wins over start_i
//  busy_o          out  1       high in any state other than IDLE
//  done_o          out  1       1-cycle pulse after last U handshake or last clear write
//  v_data_i        in   DATA_W  V sample from matrixing
//  v_valid_i       in   1       v_data_i valid
//  v_ready_o       out  1       high only in WRITE state
//  u_data_o        out  DATA_W  U sample to windowing
//  u_index_o       out  9       U index 0..511 of u_data_o
//  u_valid_o       out  1       u_data_o/u_index_o valid
//  u_ready_i       in   1       windowing accepts U
//  ram_address_o   out  ADDR_W  RAM address
//  ram_data_o      out  DATA_W  RAM write data
//  ram_write_en_o  out  1       RAM write enable
//  ram_data_i      in   DATA_W  RAM read data (valid 1 cycle after address)
// BEHAVIOUR
//  Reset: state IDLE, offset=0, all outputs 0 (busy_o, done_o, v_ready_o, u_valid_o, ram_write_en_o = 0; data/index/address = 0).
//  States: IDLE, CLEAR, WRITE, READ, FINISH.
//  IDLE: clear_i -> CLEAR (clear count k=0). Otherwise start_i -> offset:=(offset-64) mod 1024, k=0, WRITE.
//  CLEAR: 1 write/cycle of 0 to address k, k=0..1023; after k=1023 -> offset:=0, FINISH.
//  WRITE: v_ready_o=1; on v_valid_i&v_ready_o write v_data_i to (offset+k) mod 1024, k++; after k=63 handshake -> READ.
//         The RAM write is combinational from the handshake (same cycle), i.e. ram_write_en_o = v_valid_i & v_ready_o.
//  READ: U index n=0..511: i=n[8:6], j=n[4:0]; V index = i*128 + j + (n[5] ? 96 : 0); address = (offset + Vidx) mod 1024.
//   Read pipeline: address issue (cycle t) -> ram_data_i (t+1) -> 2-entry output skid buffer -> u_data_o.
//   Issue allowed when (reads in flight + skid occupancy) < 2, or a pop occurs in the same cycle; full rate with u_ready_i=1.
//   u_index_o travels with its data through the pipeline. Data is in-order and never dropped or duplicated.
//   u_valid_o/u_data_o/u_index_o are held stable while u_valid_o & !u_ready_i.
//   After handshake of n=511 -> FINISH.
//  FINISH: done_o=1 for one cycle -> IDLE. Back-to-back start_i is accepted in the first IDLE cycle.
//  ram_write_en_o is 0 in READ/FINISH/IDLE; ram_address_o is don't-care in IDLE.
//  All address arithmetic is modulo 1024 (ADDR_W-bit wrap, no saturation).
//  start_i/clear_i received while busy_o=1 have no effect; v_valid_i outside WRITE is ignored (not consumed).
//  resetn asserted mid-operation: immediate return to reset state; skid buffer is emptied and in-flight reads are discarded.
//   RAM contents are not restored; software re-issues clear_i.
// TESTING
//  1 Reset then start_i, V k=0..63 = 0x100+k -> writes to 960..1023; first U: n=0 reads addr 960 = 0x100,
//    n=32 reads addr 32 (V idx 96), u_index_o 0..511 in order, done_o 1 cycle after n=511.
//  2 17 consecutive slots -> offset sequence 960,896,...,0 then 960 (wrap); compare every U against the golden ISO V-shift model.
//  3 u_ready_i random 50% during READ -> no loss/duplication, data held under stall; u_ready_i=1 -> 512 U in 513 cycles from READ entry.
//  4 clear_i after filled buffer -> exactly 1024 zero writes, done_o, offset=0; next slot U values from untouched words read 0.
//  5 start_i/clear_i pulsed in WRITE and READ -> ignored, sequence unchanged; clear_i+start_i same cycle in IDLE -> CLEAR.
//  6 resetn low at READ n=200 -> all outputs 0 immediately, state IDLE, offset=0; new start_i runs a clean slot.

Source files
------------

// File: rtl/window_buffer_ctrl_if.sv
// Port bundle for the MP2 synthesis V-buffer sequencer: control pulses, V stream in,
// U stream out and the single-port window buffer RAM.
interface window_buffer_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              start_i;
    logic              clear_i;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] v_data_i;
    logic              v_valid_i;
    logic              v_ready_o;
    logic [DATA_W-1:0] u_data_o;
    logic [8:0]        u_index_o;
    logic              u_valid_o;
    logic              u_ready_i;
    logic [ADDR_W-1:0] ram_address_o;
    logic [DATA_W-1:0] ram_data_o;
    logic              ram_write_en_o;
    logic [DATA_W-1:0] ram_data_i;

    modport slave (
        input  start_i, clear_i, v_data_i, v_valid_i, u_ready_i, ram_data_i,
        output busy_o, done_o, v_ready_o, u_data_o, u_index_o, u_valid_o,
               ram_address_o, ram_data_o, ram_write_en_o
    );

    modport master (
        output start_i, clear_i, v_data_i, v_valid_i, u_ready_i, ram_data_i,
        input  busy_o, done_o, v_ready_o, u_data_o, u_index_o, u_valid_o,
               ram_address_o, ram_data_o, ram_write_en_o
    );
endinterface

// File: rtl/window_buffer_ctrl.sv
// MP2 synthesis filterbank V-buffer sequencer: rotates the circular offset, writes 64 V
// values per slot, then streams the 512 windowing U values in ISO 11172-3 order.
module window_buffer_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int V_BLK  = 64
) (
    input  logic                clock,
    input  logic                resetn,
    window_buffer_ctrl_if.slave bus
);

    localparam logic [8:0] LAST_U = 9'd511;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WRITE,
        READ,
        FINISH
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] offset_q;
    logic [ADDR_W-1:0] count_q;
    logic              busy_q;
    logic              done_q;
    logic              vReady_q;

    logic [9:0]        issueN_q;
    logic              inFlight_q;
    logic [8:0]        inFlightIdx_q;
    logic [DATA_W-1:0] skidData_q [2];
    logic [8:0]        skidIdx_q  [2];
    logic [1:0]        skidCount_q;

    logic              vWrite;
    logic              headValid;
    logic [DATA_W-1:0] headData;
    logic [8:0]        headIdx;
    logic              pop;
    logic              issue;
    logic [1:0]        occupancy;
    logic [ADDR_W-1:0] vIndex;

    // An empty skid buffer lets the word arriving from RAM go straight to the consumer.
    always_comb begin
        vWrite    = vReady_q & bus.v_valid_i;
        headValid = (skidCount_q != 2'd0) | inFlight_q;
        headData  = (skidCount_q != 2'd0) ? skidData_q[0] : bus.ram_data_i;
        headIdx   = (skidCount_q != 2'd0) ? skidIdx_q[0] : inFlightIdx_q;
        pop       = headValid & bus.u_ready_i;
        occupancy = skidCount_q + {1'b0, inFlight_q};
        issue     = (state_q == READ) && !issueN_q[9] && (occupancy < (pop ? 2'd3 : 2'd2));
        vIndex    = ADDR_W'({issueN_q[8:6], 7'd0}) + ADDR_W'(issueN_q[4:0])
                  + (issueN_q[5] ? ADDR_W'(96) : '0);
    end

    always_comb begin
        bus.ram_address_o = '0;
        bus.ram_data_o    = '0;
        case (state_q)
            CLEAR: bus.ram_address_o = count_q;
            WRITE: begin
                bus.ram_address_o = offset_q + count_q;
                bus.ram_data_o    = bus.v_data_i;
            end
            READ:    bus.ram_address_o = offset_q + vIndex;
            default: bus.ram_address_o = '0;
        endcase
    end

    assign bus.ram_write_en_o = (state_q == CLEAR) | vWrite;
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.v_ready_o      = vReady_q;
    assign bus.u_valid_o      = headValid;
    assign bus.u_data_o       = headValid ? headData : '0;
    assign bus.u_index_o      = headValid ? headIdx : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            offset_q      <= '0;
            count_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            vReady_q      <= 1'b0;
            issueN_q      <= '0;
            inFlight_q    <= 1'b0;
            inFlightIdx_q <= '0;
            skidData_q[0] <= '0;
            skidData_q[1] <= '0;
            skidIdx_q[0]  <= '0;
            skidIdx_q[1]  <= '0;
            skidCount_q   <= '0;
        end else begin
            inFlight_q <= issue;
            if (issue) begin
                inFlightIdx_q <= issueN_q[8:0];
                issueN_q      <= issueN_q + 10'd1;
            end

            if (pop) begin
                if (skidCount_q != 2'd0) begin
                    skidData_q[0] <= skidData_q[1];
                    skidIdx_q[0]  <= skidIdx_q[1];
                    if (inFlight_q) begin
                        if (skidCount_q == 2'd1) begin
                            skidData_q[0] <= bus.ram_data_i;
                            skidIdx_q[0]  <= inFlightIdx_q;
                        end else begin
                            skidData_q[1] <= bus.ram_data_i;
                            skidIdx_q[1]  <= inFlightIdx_q;
                        end
                    end else begin
                        skidCount_q <= skidCount_q - 2'd1;
                    end
                end
            end else if (inFlight_q) begin
                if (skidCount_q == 2'd0) begin
                    skidData_q[0] <= bus.ram_data_i;
                    skidIdx_q[0]  <= inFlightIdx_q;
                end else begin
                    skidData_q[1] <= bus.ram_data_i;
                    skidIdx_q[1]  <= inFlightIdx_q;
                end
                skidCount_q <= skidCount_q + 2'd1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.clear_i) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                    end else if (bus.start_i) begin
                        state_q  <= WRITE;
                        busy_q   <= 1'b1;
                        vReady_q <= 1'b1;
                        offset_q <= offset_q - ADDR_W'(V_BLK);
                        count_q  <= '0;
                    end
                end
                CLEAR: begin
                    count_q <= count_q + ADDR_W'(1);
                    if (count_q == '1) begin
                        offset_q <= '0;
                        state_q  <= FINISH;
                        done_q   <= 1'b1;
                    end
                end
                WRITE: begin
                    if (vWrite) begin
                        count_q <= count_q + ADDR_W'(1);
                        if (count_q == ADDR_W'(V_BLK - 1)) begin
                            state_q  <= READ;
                            vReady_q <= 1'b0;
                            issueN_q <= '0;
                        end
                    end
                end
                READ: begin
                    if (pop && headIdx == LAST_U) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_buffer_ctrl.sv
// Directed-plus-random bench for window_buffer_ctrl; U values are checked against a
// logical ISO V-shift model, independent of the physical circular addressing.
module tb_window_buffer_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    window_buffer_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    window_buffer_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .V_BLK(64)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // Single-port RAM with one cycle of read latency
    logic [DATA_W-1:0] ramMem [DEPTH] = '{default: '0};
    always @(posedge clock) begin
        if (bus.ram_write_en_o) ramMem[bus.ram_address_o] <= bus.ram_data_o;
        bus.ram_data_i <= ramMem[bus.ram_address_o];
    end

    // Logical V vector, V[0] is the newest sample; expOffset is where V[0] lives in RAM
    int                modelV [DEPTH];
    int                expOffset;
    logic [DATA_W-1:0] slotVals [64];

    function automatic int expectedU(input int n);
        int i = n / 64;
        int j = n % 64;
        if (j < 32) return modelV[i * 128 + j];
        return modelV[i * 128 + 96 + (j - 32)];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic cl, input logic vv,
                                 input logic [DATA_W-1:0] vd, input logic ur);
        @(negedge clock);
        bus.start_i   = st;
        bus.clear_i   = cl;
        bus.v_valid_i = vv;
        bus.v_data_i  = vd;
        bus.u_ready_i = ur;
        #1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_busy", bus.busy_o, 0);
        checkOutput("rst_done", bus.done_o, 0);
        checkOutput("rst_v_ready", bus.v_ready_o, 0);
        checkOutput("rst_u_valid", bus.u_valid_o, 0);
        checkOutput("rst_write_en", bus.ram_write_en_o, 0);
        checkOutput("rst_address", bus.ram_address_o, 0);
        checkOutput("rst_ram_data", bus.ram_data_o, 0);
        checkOutput("rst_u_data", bus.u_data_o, 0);
        checkOutput("rst_u_index", bus.u_index_o, 0);
    endtask

    task automatic runSlot(input bit fixedPattern, input bit validRandom, input bit readyRandom,
                           input bit injectCtrl, input int abortAt);
        int k, n, guard, readCycles;
        bit stalled;
        logic [DATA_W-1:0] heldData;
        logic [8:0] heldIdx;
        logic vv, ur, st, cl;

        for (int x = 0; x < 64; x++)
            slotVals[x] = fixedPattern ? DATA_W'(16'h100 + x) : DATA_W'($urandom);
        expOffset = (expOffset + DEPTH - 64) % DEPTH;

        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("start_busy_pre", bus.busy_o, 0);
        checkOutput("start_done_low", bus.done_o, 0);

        k = 0;
        guard = 0;
        while (k < 64 && guard < 2000) begin
            vv = validRandom ? 1'($urandom_range(0, 1)) : 1'b1;
            st = injectCtrl ? ($urandom_range(0, 7) == 0) : 1'b0;
            cl = injectCtrl ? ($urandom_range(0, 7) == 0) : 1'b0;
            applyStimulus(st, cl, vv, slotVals[k], 1'b0);
            guard++;
            if (bus.v_ready_o && vv) begin
                checkOutput("write_en", bus.ram_write_en_o, 1);
                checkOutput("write_addr", bus.ram_address_o, (expOffset + k) % DEPTH);
                checkOutput("write_data", bus.ram_data_o, slotVals[k]);
                k++;
            end else begin
                checkOutput("write_en_idle", bus.ram_write_en_o, 0);
            end
        end
        checkOutput("write_count", k, 64);

        for (int x = DEPTH - 1; x >= 64; x--) modelV[x] = modelV[x - 64];
        for (int x = 0; x < 64; x++) modelV[x] = int'(slotVals[x]);

        n = 0;
        readCycles = 0;
        stalled = 1'b0;
        heldData = '0;
        heldIdx = '0;
        guard = 0;
        while (n < 512 && n < abortAt && guard < 20000) begin
            ur = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
            st = injectCtrl ? ($urandom_range(0, 7) == 0) : 1'b0;
            cl = injectCtrl ? ($urandom_range(0, 7) == 0) : 1'b0;
            vv = 1'($urandom_range(0, 1));
            applyStimulus(st, cl, vv, DATA_W'($urandom), ur);
            guard++;
            if (readCycles == 0) checkOutput("first_read_addr", bus.ram_address_o, expOffset);
            readCycles++;
            checkOutput("read_no_write", bus.ram_write_en_o, 0);
            checkOutput("read_v_ready", bus.v_ready_o, 0);
            if (stalled) begin
                checkOutput("hold_valid", bus.u_valid_o, 1);
                checkOutput("hold_data", bus.u_data_o, heldData);
                checkOutput("hold_index", bus.u_index_o, heldIdx);
            end
            if (bus.u_valid_o && ur) begin
                checkOutput("u_index", bus.u_index_o, n);
                checkOutput("u_data", bus.u_data_o, expectedU(n));
                n++;
            end
            stalled  = bus.u_valid_o && !ur;
            heldData = bus.u_data_o;
            heldIdx  = bus.u_index_o;
        end

        if (abortAt >= 512) begin
            checkOutput("u_count", n, 512);
            if (!readyRandom) checkOutput("read_cycles", readCycles, 513);
            applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
            checkOutput("done_pulse", bus.done_o, 1);
            checkOutput("done_busy", bus.busy_o, 1);
            checkOutput("done_no_u", bus.u_valid_o, 0);
        end
    endtask

    task automatic clearBuffer(input bit withStart);
        int writes, guard;
        applyStimulus(withStart, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("clear_busy_pre", bus.busy_o, 0);
        writes = 0;
        guard = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        while (!bus.done_o && guard < 3000) begin
            checkOutput("clear_v_ready", bus.v_ready_o, 0);
            if (bus.ram_write_en_o) begin
                checkOutput("clear_addr", bus.ram_address_o, writes % DEPTH);
                checkOutput("clear_data", bus.ram_data_o, 0);
                writes++;
            end
            guard++;
            applyStimulus($urandom_range(0, 7) == 0, 1'b0, 1'($urandom_range(0, 1)),
                          DATA_W'($urandom), 1'b0);
        end
        checkOutput("clear_writes", writes, 1024);
        checkOutput("clear_done", bus.done_o, 1);
        for (int x = 0; x < DEPTH; x++) modelV[x] = 0;
        expOffset = 0;
    endtask

    initial begin
        int remapped [DEPTH];
        bus.start_i   = 1'b0;
        bus.clear_i   = 1'b0;
        bus.v_valid_i = 1'b0;
        bus.v_data_i  = '0;
        bus.u_ready_i = 1'b0;
        for (int x = 0; x < DEPTH; x++) modelV[x] = 0;
        expOffset = 0;

        #1 resetn = 1'b0;
        #1 checkResetOutputs();
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        runSlot(1'b1, 1'b0, 1'b0, 1'b0, 512);
        for (int s = 0; s < 16; s++) runSlot(1'b0, s[0], 1'b0, 1'b0, 512);

        for (int s = 0; s < 3; s++) runSlot(1'b0, 1'b1, 1'b1, 1'b0, 512);

        clearBuffer(1'b0);
        runSlot(1'b0, 1'b0, 1'b0, 1'b0, 512);

        runSlot(1'b0, 1'b1, 1'b0, 1'b1, 512);
        runSlot(1'b0, 1'b0, 1'b1, 1'b1, 512);
        clearBuffer(1'b1);
        runSlot(1'b0, 1'b0, 1'b0, 1'b0, 512);

        runSlot(1'b0, 1'b0, 1'b0, 1'b0, 200);
        #2 resetn = 1'b0;
        #1 checkResetOutputs();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkResetOutputs();
        resetn = 1'b1;
        for (int x = 0; x < DEPTH; x++) remapped[x] = modelV[(x - expOffset + DEPTH) % DEPTH];
        for (int x = 0; x < DEPTH; x++) modelV[x] = remapped[x];
        expOffset = 0;
        runSlot(1'b0, 1'b0, 1'b0, 1'b0, 512);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
